btn_debounce: RTL and testbench

//  - Cleans a raw mechanical push-button input (bouncing, asynchronous to sys_clk).
//  - Produces a glitch-free, synchronous, active-high level o_btn.
//  - o_btn feeds i_btn of edge_det directly. edge_det then derives posedge_flag/negedge_flag.
//  - Sits between the board pin and edge_det; one instance per button.

---
 rtl/btn_debounce_pkg.sv | 25 ++
 rtl/btn_debounce_sync_ff.sv | 25 ++
 rtl/btn_debounce.sv | 114 +++++++++++
 tb/tb_btn_debounce.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: filter FSM encoding,
// default timing constants and small state-decoding helpers.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_FILT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_FILT = 2'd3
    } btn_state_t;

    // 20 ms of stable input at a 50 MHz system clock.
    localparam int BTN_DEBOUNCE_CYCLES_50MHZ = 1_000_000;
    localparam int BTN_SYNC_STAGES_DEF       = 2;

    // The accepted level stays "pressed" while a release is still being filtered.
    function automatic logic btn_level(input btn_state_t st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_FILT);
    endfunction

    function automatic logic btn_filtering(input btn_state_t st);
        return (st == ST_PRESS_FILT) || (st == ST_RELEASE_FILT);
    endfunction

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// Plain flop-chain synchronizer for asynchronous pin inputs; the reset value
// lets each pin come out of reset at its idle level.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Debounces one raw push-button pin into a synchronous active-high level;
// a level change is accepted only after it has been stable for DEBOUNCE_CYCLES+1 samples.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = BTN_SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_50MHZ,
    parameter logic ACTIVE_LOW      = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key_raw,
    output logic o_btn,
    output logic o_busy
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             w_key_sync;
    logic             w_pressed;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_btn;
    logic             r_busy;
    logic             w_btn_nxt;
    logic             w_busy_nxt;

    // Reset loads the released pin level so no phantom press follows reset.
    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_d       (i_key_raw),
        .o_q       (w_key_sync)
    );

    assign w_pressed = w_key_sync ^ ACTIVE_LOW;

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
            r_btn   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_btn   <= w_btn_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Counter restarts on every state change, so it can never pass CNT_LAST.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RELEASED: begin
                if (w_pressed) begin
                    w_state_nxt = ST_PRESS_FILT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_FILT: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_RELEASE_FILT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_FILT: begin
                if (w_pressed) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the FSM.
    always_comb begin
        w_btn_nxt  = btn_level(w_state_nxt);
        w_busy_nxt = btn_filtering(w_state_nxt);
    end

    assign o_btn  = r_btn;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus randomized bounce
// sequences, checked against a run-length reference model of the filter.
module tb_btn_debounce;

    localparam int   SYNC = 2;
    localparam int   DEB  = 8;
    localparam logic AL   = 1'b1;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;
    logic i_key_raw = 1'b1;
    logic o_btn;
    logic o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    btn_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (AL)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_key_raw (i_key_raw),
        .o_btn     (o_btn),
        .o_busy    (o_busy)
    );

    // Reference: pressed-level samples reach the filter SYNC edges late; the
    // output flips once the sample has disagreed with it for DEB+1 edges in a row.
    logic m_pipe [SYNC];
    logic m_s;
    logic m_btn  = 1'b0;
    logic m_busy = 1'b0;
    int   m_run  = 0;
    int   m_rise = 0;
    int   m_fall = 0;

    initial begin
        forever begin
            @(posedge sys_clk or posedge sys_rst_n);
            if (sys_rst_n) begin
                for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
                m_btn  = 1'b0;
                m_busy = 1'b0;
                m_run  = 0;
            end else begin
                m_s = m_pipe[SYNC-1];
                for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
                m_pipe[0] = i_key_raw ^ AL;
                if (m_s != m_btn) begin
                    m_run++;
                    if (m_run == DEB + 1) begin
                        m_btn = ~m_btn;
                        m_run = 0;
                        if (m_btn) m_rise++;
                        else       m_fall++;
                    end
                end else begin
                    m_run = 0;
                end
                m_busy = (m_run != 0);
            end
        end
    end

    // Stand-in for the downstream edge detector: count o_btn edges.
    int d_rise = 0;
    int d_fall = 0;
    initial forever begin @(posedge o_btn); d_rise++; end
    initial forever begin @(negedge o_btn); d_fall++; end

    task automatic test_reset();
        sys_rst_n = 1'b1;
        i_key_raw = 1'b1;
        #20;
        n_checks++;
        if (o_btn !== 1'b0) begin
            n_fail++; $display("FAIL reset_btn: got %b, expected 0", o_btn);
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b, expected 0", o_busy);
        end
        sys_rst_n = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge sys_clk);
            n_checks++;
            if (o_btn !== 1'b0 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset: btn/busy=%b/%b, expected 0/0", o_btn, o_busy);
            end
        end
    endtask

    task automatic release_clean();
        i_key_raw = 1'b1;
        repeat (20) @(negedge sys_clk);
        n_checks++;
        if (o_btn !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_released: btn/busy=%b/%b, expected 0/0", o_btn, o_busy);
        end
    endtask

    task automatic test_press();
        logic eb;
        logic ey;
        @(negedge sys_clk);
        i_key_raw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge sys_clk);
            eb = (k >= SYNC + DEB + 1);
            ey = (k >= SYNC + 1) && (k < SYNC + DEB + 1);
            n_checks++;
            if (o_btn !== eb || o_busy !== ey) begin
                n_fail++;
                $display("FAIL press_latency k=%0d: btn/busy=%b/%b, expected %b/%b", k, o_btn, o_busy, eb, ey);
            end
            n_checks++;
            if (o_btn !== m_btn || o_busy !== m_busy) begin
                n_fail++;
                $display("FAIL press_model k=%0d: btn/busy=%b/%b, model %b/%b", k, o_btn, o_busy, m_btn, m_busy);
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            n_checks++;
            if (o_btn !== 1'b1 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL press_hold: btn/busy=%b/%b, expected 1/0", o_btn, o_busy);
            end
        end
    endtask

    task automatic test_glitch();
        logic saw_busy;
        logic saw_btn;
        saw_busy = 1'b0;
        saw_btn  = 1'b0;
        @(negedge sys_clk);
        i_key_raw = 1'b0;
        repeat (DEB) @(negedge sys_clk);
        i_key_raw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (o_busy === 1'b1) saw_busy = 1'b1;
            n_checks++;
            if (o_btn !== 1'b0) begin
                n_fail++; $display("FAIL glitch8_btn k=%0d: got %b, expected 0", k, o_btn);
            end
            n_checks++;
            if (o_busy !== m_busy) begin
                n_fail++; $display("FAIL glitch8_busy k=%0d: got %b, model %b", k, o_busy, m_busy);
            end
        end
        n_checks++;
        if (saw_busy !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch8_busy_pulse: saw=%b end=%b, expected 1/0", saw_busy, o_busy);
        end
        i_key_raw = 1'b0;
        repeat (DEB + 1) @(negedge sys_clk);
        i_key_raw = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge sys_clk);
            if (o_btn === 1'b1) saw_btn = 1'b1;
            n_checks++;
            if (o_btn !== m_btn || o_busy !== m_busy) begin
                n_fail++;
                $display("FAIL glitch9_model k=%0d: btn/busy=%b/%b, model %b/%b", k, o_btn, o_busy, m_btn, m_busy);
            end
        end
        n_checks++;
        if (saw_btn !== 1'b1 || o_btn !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch9_accept: saw=%b end=%b, expected 1/0", saw_btn, o_btn);
        end
    endtask

    task automatic test_bounce_release();
        int   f0;
        logic eb;
        @(negedge sys_clk);
        i_key_raw = 1'b0;
        repeat (15) @(negedge sys_clk);
        n_checks++;
        if (o_btn !== 1'b1) begin
            n_fail++; $display("FAIL bounce_pressed: got %b, expected 1", o_btn);
        end
        f0 = d_fall;
        for (int t = 0; t < 9; t++) begin
            i_key_raw = (t % 2 == 0) ? 1'b1 : 1'b0;
            if (t < 8) begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge sys_clk);
                    n_checks++;
                    if (o_btn !== 1'b1 || o_busy !== m_busy) begin
                        n_fail++;
                        $display("FAIL bounce_hold t=%0d: btn/busy=%b/%b, expected 1/%b", t, o_btn, o_busy, m_busy);
                    end
                end
            end
        end
        for (int k = 1; k <= 14; k++) begin
            @(negedge sys_clk);
            eb = (k < SYNC + DEB + 1);
            n_checks++;
            if (o_btn !== eb) begin
                n_fail++; $display("FAIL bounce_latency k=%0d: got %b, expected %b", k, o_btn, eb);
            end
        end
        n_checks++;
        if (d_fall - f0 != 1) begin
            n_fail++; $display("FAIL bounce_single_fall: got %0d falls, expected 1", d_fall - f0);
        end
    endtask

    task automatic test_reset_midfilter();
        logic eb;
        @(negedge sys_clk);
        i_key_raw = 1'b0;
        repeat (SYNC + 5) @(negedge sys_clk);
        n_checks++;
        if (o_busy !== 1'b1 || o_btn !== 1'b0) begin
            n_fail++;
            $display("FAIL midfilter_pre: btn/busy=%b/%b, expected 0/1", o_btn, o_busy);
        end
        sys_rst_n = 1'b1;
        #1;
        n_checks++;
        if (o_btn !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midfilter_abort: btn/busy=%b/%b, expected 0/0", o_btn, o_busy);
        end
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if (o_btn !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midfilter_held: btn/busy=%b/%b, expected 0/0", o_btn, o_busy);
        end
        sys_rst_n = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge sys_clk);
            eb = (k >= SYNC + DEB + 1);
            n_checks++;
            if (o_btn !== eb) begin
                n_fail++; $display("FAIL midfilter_repress k=%0d: got %b, expected %b", k, o_btn, eb);
            end
        end
    endtask

    task automatic test_random_chain();
        int r0, f0, mr0, mf0, nb, d;
        r0 = d_rise; f0 = d_fall; mr0 = m_rise; mf0 = m_fall;
        for (int p = 0; p < 10; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                nb = $urandom_range(1, 5);
                for (int b = 0; b < 2 * nb + 1; b++) begin
                    // ph 0 settles low (press), ph 1 settles high (release)
                    i_key_raw = (b % 2 == 0) ? ph[0] : ~ph[0];
                    d = (b == 2 * nb) ? $urandom_range(DEB + 6, DEB + 20) : $urandom_range(1, DEB);
                    for (int c = 0; c < d; c++) begin
                        @(negedge sys_clk);
                        n_checks++;
                        if (o_btn !== m_btn || o_busy !== m_busy) begin
                            n_fail++;
                            $display("FAIL random_model p=%0d: btn/busy=%b/%b, model %b/%b", p, o_btn, o_busy, m_btn, m_busy);
                        end
                    end
                end
            end
        end
        n_checks++;
        if (d_rise - r0 != 10 || d_fall - f0 != 10) begin
            n_fail++;
            $display("FAIL random_edge_count: rises=%0d falls=%0d, expected 10/10", d_rise - r0, d_fall - f0);
        end
        n_checks++;
        if (m_rise - mr0 != 10 || m_fall - mf0 != 10) begin
            n_fail++;
            $display("FAIL random_model_count: rises=%0d falls=%0d, expected 10/10", m_rise - mr0, m_fall - mf0);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        release_clean();
        test_glitch();
        release_clean();
        test_bounce_release();
        release_clean();
        test_reset_midfilter();
        release_clean();
        test_random_chain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
